// File: rtl/pipe_if_stage_q.sv
// Instruction-fetch stage: PC/next-PC selection, single-outstanding imem
// request/grant/response handshake, and a DEPTH-entry fetch queue feeding decode.
module pipe_if_stage_q #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] EXC_BASE = XLEN'(32'h0000_0008)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pcsource,
    input  logic [1:0]      selpc,
    input  logic [XLEN-1:0] bpc,
    input  logic [XLEN-1:0] da,
    input  logic [XLEN-1:0] jpc,
    input  logic [XLEN-1:0] epc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4
);
    localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW        = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            outstanding_q, outstanding_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] inst_q     [DEPTH];
    logic [XLEN-1:0] entry_pc_q [DEPTH];

    logic            redir, grant, push, pop;
    logic [XLEN-1:0] target;
    logic [CW:0]     occ;

    always_comb begin
        redir  = (selpc == 2'b01) | (selpc == 2'b10) | (pcsource != 2'b00);
        target = pc_q;
        if (selpc == 2'b01) begin
            target = epc;
        end else if (selpc == 2'b10) begin
            target = EXC_BASE;
        end else begin
            unique case (pcsource)
                2'b01:   target = bpc;
                2'b10:   target = da;
                2'b11:   target = jpc;
                default: target = pc_q;
            endcase
        end
    end

    // The outstanding request already owns a queue slot, so occupancy counts it.
    always_comb begin
        occ       = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};
        imem_req  = !rst && !redir && (!outstanding_q || imem_rvalid) && (occ < DEPTH_OCC);
        imem_addr = pc_q;
        grant     = imem_req && imem_gnt;
        push      = imem_rvalid && !redir && !discard_q;
        if_valid  = !rst && (count_q != '0);
        pop       = if_valid && if_ready;
        if_inst   = if_valid ? inst_q[head_q] : '0;
        if_pc     = if_valid ? entry_pc_q[head_q] : '0;
        if_pc4    = if_valid ? entry_pc_q[head_q] + FOUR : '0;
    end

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redir) begin
            pc_d          = target;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            // A response still in flight belongs to the old path and must be dropped.
            outstanding_d = outstanding_q && !imem_rvalid;
            discard_d     = outstanding_q && !imem_rvalid;
        end else begin
            if (imem_rvalid) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end
            if (grant) begin
                pc_d          = pc_q + FOUR;
                req_pc_d      = pc_q;
                outstanding_d = 1'b1;
            end
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            inst_q[tail_q]     <= imem_rdata;
            entry_pc_q[tail_q] <= req_pc_q;
        end
    end
endmodule

// File: tb/tb_pipe_if_stage_q.sv
// Directed bench for pipe_if_stage_q with a variable-latency instruction memory model.
module tb_pipe_if_stage_q;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsource, selpc;
    logic [31:0] bpc, da, jpc, epc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, if_ready;
    logic [31:0] if_inst, if_pc, if_pc4;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 1;
    logic        mem_pend = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = '0;

    always #5 clk = ~clk;

    pipe_if_stage_q #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .EXC_BASE(32'h8)) dut (
        .clk(clk), .rst(rst), .pcsource(pcsource), .selpc(selpc),
        .bpc(bpc), .da(da), .jpc(jpc), .epc(epc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, then advance the memory model.
    task automatic tick();
        logic        fire, rv_was;
        logic [31:0] fa;
        #1;
        fire   = imem_req & imem_gnt;
        fa     = imem_addr;
        rv_was = imem_rvalid;
        @(posedge clk);
        #1;
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (rv_was) mem_pend = 1'b0;
            else if (mem_pend && mem_wait > 0) mem_wait--;
            if (fire) begin
                mem_pend = 1'b1;
                mem_wait = mem_lat - 1;
                mem_addr = fa;
            end
        end
        imem_rvalid = mem_pend && (mem_wait == 0);
        imem_rdata  = imem_rvalid ? (mem_addr ^ 32'hA5A5_0000) : 32'h0;
        $display("t=%0t req=%0b addr=%h rvalid=%0b valid=%0b pc=%h inst=%h",
                 $time, imem_req, imem_addr, imem_rvalid, if_valid, if_pc, if_inst);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pcsource = 2'b00; selpc = 2'b00;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic redirect_test(input string tag, input logic [1:0] sel,
                                 input logic [1:0] src, input logic [31:0] tgt);
        int n;
        selpc = sel; pcsource = src;
        #1;
        chk({tag, "_req_low"}, {31'b0, imem_req}, 32'd0);
        tick();
        selpc = 2'b00; pcsource = 2'b00;
        #1;
        n = 0;
        while (!imem_req && n < 50) begin tick(); n++; end
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, tgt);
        n = 0;
        while (!if_valid && n < 50) begin tick(); n++; end
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        chk({tag, "_pc"}, if_pc, tgt);
        chk({tag, "_pc4"}, if_pc4, tgt + 32'd4);
        chk({tag, "_inst"}, if_inst, tgt ^ 32'hA5A5_0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; pcsource = 2'b00; selpc = 2'b00;
        bpc = 32'h100; da = 32'h80; jpc = 32'h200; epc = 32'h40;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;

        // Reset and fill under back-pressure
        #1;
        chk("rst0_req", {31'b0, imem_req}, 32'd0);
        chk("rst0_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc4", if_pc4, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("r0_req", {31'b0, imem_req}, 32'd1);
        chk("r0_addr", imem_addr, 32'h0);
        chk("r0_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("r1_addr", imem_addr, 32'h4);
        chk("r1_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("r2_valid", {31'b0, if_valid}, 32'd1);
        chk("r2_pc", if_pc, 32'h0);
        chk("r2_pc4", if_pc4, 32'h4);
        chk("r2_inst", if_inst, 32'hA5A5_0000);
        chk("r2_addr", imem_addr, 32'h8);
        tick();
        chk("r3_addr", imem_addr, 32'hC);
        tick();
        chk("bp_req_r4", {31'b0, imem_req}, 32'd0);
        tick();
        chk("bp_req_r5", {31'b0, imem_req}, 32'd0);
        chk("bp_head", if_pc, 32'h0);
        if_ready = 1'b1;
        #1;
        chk("bp_pop_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("bp_rearm_req", {31'b0, imem_req}, 32'd1);
        chk("bp_rearm_addr", imem_addr, 32'h10);

        // Streaming at one instruction per cycle
        for (int k = 0; k < 8; k++) begin
            chk("stream_valid", {31'b0, if_valid}, 32'd1);
            chk("stream_pc", if_pc, 32'(4 + 4 * k));
            chk("stream_inst", if_inst, 32'(4 + 4 * k) ^ 32'hA5A5_0000);
            tick();
        end

        // Branch while the 0x20 fetch is outstanding, memory latency 3
        mem_lat = 3;
        do_reset();
        n = 0;
        while (!(imem_req && imem_addr == 32'h20) && n < 200) begin tick(); n++; end
        chk("br_find20", {31'b0, imem_req && imem_addr == 32'h20}, 32'd1);
        tick();
        pcsource = 2'b01;
        #1;
        chk("br_req_low", {31'b0, imem_req}, 32'd0);
        tick();
        pcsource = 2'b00;
        #1;
        chk("br_n1_valid", {31'b0, if_valid}, 32'd0);
        chk("br_n1_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("br_n2_valid", {31'b0, if_valid}, 32'd0);
        chk("br_n2_req", {31'b0, imem_req}, 32'd1);
        chk("br_n2_addr", imem_addr, 32'h100);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("br_empty", {31'b0, if_valid}, 32'd0);
        end
        tick();
        chk("br_valid", {31'b0, if_valid}, 32'd1);
        chk("br_pc", if_pc, 32'h100);
        chk("br_inst", if_inst, 32'h100 ^ 32'hA5A5_0000);

        // Exception, register jump, return with priority, wrap-around
        mem_lat = 1;
        redirect_test("exc", 2'b10, 2'b00, 32'h8);
        redirect_test("da", 2'b00, 2'b10, 32'h80);
        redirect_test("eret", 2'b01, 2'b11, 32'h40);
        jpc = 32'hFFFF_FFFC;
        redirect_test("wrap", 2'b00, 2'b11, 32'hFFFF_FFFC);
        tick();
        chk("wrap_next_valid", {31'b0, if_valid}, 32'd1);
        chk("wrap_next_pc", if_pc, 32'h0);
        chk("wrap_next_inst", if_inst, 32'hA5A5_0000);

        // Reset in mid-stream abandons everything in flight
        rst = 1'b1;
        #1;
        chk("mrst_req", {31'b0, imem_req}, 32'd0);
        chk("mrst_valid", {31'b0, if_valid}, 32'd0);
        chk("mrst_inst", if_inst, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("mrst_rel_req", {31'b0, imem_req}, 32'd1);
        chk("mrst_rel_addr", imem_addr, 32'h0);
        chk("mrst_rel_valid", {31'b0, if_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_if_stage_q.md
# pipe_if_stage_q

Parametrised instruction-fetch stage for the pipelined MIPS core, succeeding the combinational IF stage. It owns the PC register and next-PC selection, covering sequential, branch, register jump, jump, EPC return and exception vector. It drives a variable-latency instruction memory through a request/grant/response handshake and buffers fetched instructions in a DEPTH-entry queue. Decode consumes the queue through a valid/ready handshake, which replaces the single-register IF/ID stall.

## Interface
- XLEN, 32: address/data width
- DEPTH, 4: fetch queue entries (≥2)
- RESET_PC, 32'h0000_0000: PC after reset
- EXC_BASE, 32'h0000_0008: exception vector
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pcsource  in  2  00 seq, 01 bpc, 10 da, 11 jpc
- selpc  in  2  00 use pcsource, 01 epc, 10 EXC_BASE, 11 treated as 00
- bpc, da, jpc, epc  in  XLEN  redirect targets
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid, in order, ≥1 cycle after grant
- imem_rdata  in  XLEN  instruction word
- if_valid  out  1  queue head valid
- if_ready  in  1  decode accepts head
- if_inst, if_pc, if_pc4  out  XLEN  head instruction, its address, address+4

## Operation
- **Redirect.** `redir = (selpc==01) | (selpc==10) | (pcsource!=00)`. `selpc` has priority over `pcsource`.
- **Target.** With `redir`:
  - `selpc==01`: target = epc.
  - `selpc==10`: target = EXC_BASE.
  - Otherwise: bpc, da or jpc per `pcsource`.
- **Redirect actions.** On a redirect cycle:
  - pc <= target.
  - The queue is cleared (count <= 0).
  - `imem_req` is held low.
  - If a request is outstanding and `imem_rvalid` is low that cycle, the discard flag is set.
  - An `imem_rvalid` arriving in the redirect cycle is dropped and clears outstanding.
- **Issue.**
  - `imem_req = !rst & !redir & (!outstanding | imem_rvalid) & (count + outstanding < DEPTH)`.
  - On `imem_req & imem_gnt`: pc <= pc+4 (mod 2^XLEN), outstanding <= 1, and the request pc is latched as req_pc.
  - At most one request is outstanding.
- **Response.** On `imem_rvalid` without redirect:
  - If discard is set, the word is dropped and discard <= 0.
  - Otherwise {req_pc, req_pc+4, imem_rdata} is pushed at the tail.
  - In both cases outstanding <= 0 unless a new grant occurs the same cycle.
- **Pop.** On `if_valid & if_ready`, the head advances.
  - Push and pop in the same cycle leave count unchanged.
  - Pop on empty is a no-op.
  - Overflow cannot occur because the issue rule reserves a slot per outstanding request.
- **Pointers.** Head/tail are mod-DEPTH counters; count is 0..DEPTH.
- **Head outputs.** `if_valid = (count != 0)`. `if_inst`/`if_pc`/`if_pc4` show the head entry and are driven 0 when empty.
- **Arithmetic.** All PC arithmetic is XLEN-bit unsigned with wrap.

## Timing
- **Reset.**
  - Reset values: pc=RESET_PC, count=0, head=tail=0, outstanding=0, discard=0.
  - Outputs during reset: imem_req=0, if_valid=0, if_inst/if_pc/if_pc4=0.
  - Reset mid-operation abandons the in-flight request. Any `imem_rvalid` during reset is ignored.
  - The memory side must not return a stale response after reset is released.
- **Throughput.** With 1-cycle memory latency (rvalid the cycle after grant), one instruction is fetched per cycle.
- **Redirect latency.** Redirect in cycle N:
  - imem_addr=target, req=1 in N+1.
  - rvalid in N+2.
  - if_valid with the target instruction in N+3.
- **Discard rule.** The discard flag drops exactly one response: the first rvalid after the redirect.
- **Back-pressure.**
  - With if_ready=0, the queue fills to DEPTH, then imem_req stays 0.
  - When if_ready rises, the first pop frees a slot and imem_req rises in the following cycle.
- **Next-PC timing.** Redirect inputs are sampled every cycle; no registered next-PC delay.

## Test plan
- **Reset.** rst=1 for 2 cycles, then release with gnt=1 and 1-cycle memory → req=1 at 0x0, then at 0x4 and 0x8. if_valid is asserted two cycles after release with if_pc=0x0 and if_pc4=0x4.
- **Stream.** if_ready=1, memory returns word=addr ^ 0xA5A5_0000 → if_pc 0x0, 0x4, 0x8, … on consecutive cycles, with if_inst matching.
- **Back-pressure.** if_ready=0, DEPTH=4 → count reaches 4 and req stays 0. Set if_ready=1 for one cycle → head 0x0 pops and req reasserts next cycle at 0x10.
- **Branch with outstanding fetch.** Memory latency 3; assert pcsource=01, bpc=0x100 while a request for 0x20 is outstanding → the 0x20 response is dropped, the next if_pc is 0x100, and the queue is empty in between.
- **Exception and return.** Assert selpc=10 → next fetch is at 0x8. Later assert selpc=01, epc=0x40 together with pcsource=11 → fetch is at 0x40 (selpc priority).
- **Wrap-around.** Redirect jpc=0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0; if_pc4 of the first instruction is 0x0.
